// File: rtl/shift_add_multiplier_if.sv
// Handshake bundle for shift_add_multiplier.
//   master: operand producer / product consumer (drives in_valid, a, b, out_ready)
//   slave : the multiplier (drives in_ready, out_valid, product, busy)
interface shift_add_multiplier_if #(
  parameter int unsigned WIDTH = 64
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier.
// One WIDTH-bit add with carry-out plus a right shift per cycle; the full
// 2*WIDTH-bit product is available WIDTH cycles after the operands are accepted.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of shift_add_multiplier_if:
//          in_valid/in_ready/a/b   operand handshake (in_ready only in IDLE)
//          out_valid/out_ready     product handshake (out_valid only in DONE)
//          product                 a*b, held until the next completed operation
//          busy                    high in RUN or DONE
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  shift_add_multiplier_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_m;        // multiplicand
  logic [2*WIDTH:0]     r_p;        // {carry, hi, lo} accumulator
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;

  logic [WIDTH:0]       w_sum;      // WIDTH+1 bits so the carry-out is kept
  logic [2*WIDTH:0]     w_p_next;

  always_comb begin
    w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
    // Logical right shift of {carry, hi, lo}; the vacated MSB is zero.
    w_p_next = {1'b0, w_sum, r_p[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_m         <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
      r_product   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_m        <= bus.a;
            r_p        <= {1'b0, {WIDTH{1'b0}}, bus.b};
            r_cnt      <= '0;
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          r_p   <= w_p_next;
          r_cnt <= r_cnt + CNT_W'(1);
          // Counter value WIDTH-1 marks the WIDTH-th iteration; the product
          // register is loaded from the same next-state value.
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state     <= DONE;
            r_product   <= w_p_next[2*WIDTH-1:0];
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.product   = r_product;

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;
  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;

  shift_add_multiplier_if #(.WIDTH(W)) bus ();

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [2*W-1:0] sb_q[$];

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; push expected product on the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit keep_valid, output bit timed_out);
    int waited;
    waited    = 0;
    timed_out = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    while (bus.in_ready !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    if (bus.in_ready !== 1'b1) timed_out = 1'b1;
    else begin
      tick();
      sb_q.push_back((2*W)'(a) * (2*W)'(b));
    end
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cycles, output bit timed_out);
    cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
    timed_out = (bus.out_valid !== 1'b1);
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    #12;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.product !== '0) begin n_fail++; $display("FAIL reset_product got=%h exp=0", bus.product); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_basic();
    bit to;
    int cyc;
    logic [2*W-1:0] exp;
    issue(8'd3, 8'd5, 1'b0, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL basic_accept timeout"); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready_fall got=%b exp=0", bus.in_ready); end
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_run cyc=%0d got=%b exp=1", cyc, bus.busy); end
      tick();
      cyc++;
    end
    n_cmp++; if (cyc != W) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", cyc, W); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_done got=%b exp=1", bus.busy); end
    exp = sb_q.pop_front();
    n_cmp++; if (bus.product !== exp) begin n_fail++; $display("FAIL basic_product got=%0d exp=%0d", bus.product, exp); end
    handshake();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_return ov=%b ir=%b exp ov=0 ir=1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_max();
    bit to;
    int cyc;
    logic [2*W-1:0] exp;
    bus.out_ready = 1'b1;
    issue(8'd255, 8'd255, 1'b0, to);
    wait_out(cyc, to);
    n_cmp++; if (to || cyc != W) begin n_fail++; $display("FAIL max_latency got=%0d exp=%0d", cyc, W); end
    exp = sb_q.pop_front();
    n_cmp++; if (bus.product !== 16'hFE01 || exp !== 16'hFE01) begin n_fail++; $display("FAIL max_product got=%h exp=%h", bus.product, exp); end
    tick();
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL max_return ir=%b ov=%b exp ir=1 ov=0", bus.in_ready, bus.out_valid); end
    n_cmp++; if (bus.product !== 16'hFE01) begin n_fail++; $display("FAIL max_product_hold_idle got=%h exp=fe01", bus.product); end
  endtask

  task automatic test_zero_and_edge();
    logic [W-1:0] ta[3];
    logic [W-1:0] tb[3];
    bit to;
    int cyc;
    logic [2*W-1:0] exp;
    ta = '{8'd0, 8'd200, 8'd1};
    tb = '{8'd200, 8'd0, 8'h80};
    for (int i = 0; i < 3; i++) begin
      issue(ta[i], tb[i], 1'b0, to);
      wait_out(cyc, to);
      n_cmp++; if (to || cyc != W) begin n_fail++; $display("FAIL edge_latency[%0d] got=%0d exp=%0d", i, cyc, W); end
      exp = sb_q.pop_front();
      n_cmp++; if (bus.product !== exp) begin n_fail++; $display("FAIL edge_product[%0d] got=%h exp=%h", i, bus.product, exp); end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int cyc;
    int hs;
    logic [2*W-1:0] exp;
    issue(8'd17, 8'd13, 1'b0, to);
    wait_out(cyc, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL bp_out_valid timeout"); end
    exp = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.product !== exp) begin n_fail++; $display("FAIL bp_hold[%0d] ov=%b prod=%0d exp ov=1 prod=%0d", i, bus.out_valid, bus.product, exp); end
    end
    hs = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid === 1'b1) hs++;
      tick();
    end
    bus.out_ready = 1'b0;
    n_cmp++; if (hs != 1) begin n_fail++; $display("FAIL bp_handshakes got=%0d exp=1", hs); end
    n_cmp++; if (bus.product !== 16'd221) begin n_fail++; $display("FAIL bp_product_after got=%0d exp=221", bus.product); end
  endtask

  task automatic test_back_to_back();
    bit to;
    int cyc;
    logic [2*W-1:0] exp;
    issue(8'd6, 8'd7, 1'b1, to);
    // second pair presented during RUN and held
    bus.a = 8'd9;
    bus.b = 8'd9;
    wait_out(cyc, to);
    n_cmp++; if (to || cyc != W) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", cyc, W); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_done got=%b exp=0", bus.in_ready); end
    exp = sb_q.pop_front();
    n_cmp++; if (bus.product !== exp) begin n_fail++; $display("FAIL b2b_first got=%0d exp=%0d", bus.product, exp); end
    handshake();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got=%b exp=1", bus.in_ready); end
    issue(8'd9, 8'd9, 1'b0, to);
    wait_out(cyc, to);
    n_cmp++; if (to || cyc != W) begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=%0d", cyc, W); end
    exp = sb_q.pop_front();
    n_cmp++; if (bus.product !== exp || exp !== 16'd81) begin n_fail++; $display("FAIL b2b_second got=%0d exp=81", bus.product); end
    handshake();
  endtask

  task automatic test_reset_mid_run();
    bit to;
    bit seen;
    int cyc;
    logic [2*W-1:0] exp;
    issue(8'd100, 8'd3, 1'b0, to);
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl ir=%b ov=%b busy=%b exp 1/0/0", bus.in_ready, bus.out_valid, bus.busy); end
    n_cmp++; if (bus.product !== '0) begin n_fail++; $display("FAIL midrst_product got=%h exp=0", bus.product); end
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL midrst_no_output got=1 exp=0"); end
    issue(8'd2, 8'd2, 1'b0, to);
    wait_out(cyc, to);
    n_cmp++; if (to || cyc != W) begin n_fail++; $display("FAIL midrst_next_latency got=%0d exp=%0d", cyc, W); end
    exp = sb_q.pop_front();
    n_cmp++; if (bus.product !== exp || exp !== 16'd4) begin n_fail++; $display("FAIL midrst_next_product got=%0d exp=4", bus.product); end
    handshake();
    n_cmp++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero_and_edge();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
